// File: rtl/cnn_mem_rd_arb.sv
// cnn_mem_rd_arb: shares the memory read port between the pic, wgt and bias
// read channels of the cnn core.
//
// One requester is granted per transaction. Its address and size are
// registered and held on mem_start_addr / mem_size_bytes. Response beats
// are routed combinationally to the granted requester only.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   <r>_req/addr/size   requester read channels (r = pic, wgt, bias)
//   <r>_valid/last      routed response strobes
//   rd_data             mem_data broadcast to all requesters
//   rd_last_valid       mem_last_valid broadcast to all requesters
//   mem_*               memory-side read request and response
//   gnt_id              0 none, 1 pic, 2 wgt, 3 bias
//   beat_cnt            beats of the current or last transaction (saturates)
//   timeout_err         sticky no-response watchdog error
//
// Build option: define CNN_RD_ARB_RR_EN for round-robin arbitration
// (default is fixed priority bias > wgt > pic).
module cnn_mem_rd_arb #(
    parameter int ADDR_WIDTH           = 19,
    parameter int LOG2_MAX_BYTES_TO_RD = 5,
    parameter int MEM_DATA_BUS         = 256,
    parameter int LAST_VALID_W         = 5,
    parameter int TIMEOUT_CYC          = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pic_req,
    input  logic                            wgt_req,
    input  logic                            bias_req,
    input  logic [ADDR_WIDTH-1:0]           pic_addr,
    input  logic [ADDR_WIDTH-1:0]           wgt_addr,
    input  logic [ADDR_WIDTH-1:0]           bias_addr,
    input  logic [LOG2_MAX_BYTES_TO_RD-1:0] pic_size,
    input  logic [LOG2_MAX_BYTES_TO_RD-1:0] wgt_size,
    input  logic [LOG2_MAX_BYTES_TO_RD-1:0] bias_size,
    output logic                            pic_valid,
    output logic                            wgt_valid,
    output logic                            bias_valid,
    output logic                            pic_last,
    output logic                            wgt_last,
    output logic                            bias_last,
    output logic [MEM_DATA_BUS-1:0]         rd_data,
    output logic [LAST_VALID_W-1:0]         rd_last_valid,
    output logic                            mem_req,
    output logic [ADDR_WIDTH-1:0]           mem_start_addr,
    output logic [LOG2_MAX_BYTES_TO_RD-1:0] mem_size_bytes,
    input  logic                            mem_valid,
    input  logic                            mem_last,
    input  logic [MEM_DATA_BUS-1:0]         mem_data,
    input  logic [LAST_VALID_W-1:0]         mem_last_valid,
    output logic [1:0]                      gnt_id,
    output logic [7:0]                      beat_cnt,
    output logic                            timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_nxt;

    logic [1:0]                      win_id;
    logic [ADDR_WIDTH-1:0]           win_addr;
    logic [LOG2_MAX_BYTES_TO_RD-1:0] win_size;
    logic                            busy;
    logic                            got_beat;
    logic [WD_W-1:0]                 wd_cnt;
    logic                            wd_fire;
    logic                            done;
    logic                            grant;

    assign busy  = (state == BUSY);
    assign done  = busy && mem_valid && mem_last;
    assign grant = (state == IDLE) && (win_id != 2'd0);
    // A beat in the final watchdog cycle still counts as a response.
    assign wd_fire = busy && !got_beat && !mem_valid &&
                     (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

`ifdef CNN_RD_ARB_RR_EN
    logic [1:0] last_id;

    // Search starts at the requester after the last granted one.
    always_comb begin
        win_id = 2'd0;
        case (last_id)
            2'd1: begin
                if (wgt_req)       win_id = 2'd2;
                else if (bias_req) win_id = 2'd3;
                else if (pic_req)  win_id = 2'd1;
            end
            2'd2: begin
                if (bias_req)      win_id = 2'd3;
                else if (pic_req)  win_id = 2'd1;
                else if (wgt_req)  win_id = 2'd2;
            end
            default: begin
                if (pic_req)       win_id = 2'd1;
                else if (wgt_req)  win_id = 2'd2;
                else if (bias_req) win_id = 2'd3;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_id <= 2'd3;
        else if (grant)
            last_id <= win_id;
    end
`else
    always_comb begin
        win_id = 2'd0;
        if (bias_req)     win_id = 2'd3;
        else if (wgt_req) win_id = 2'd2;
        else if (pic_req) win_id = 2'd1;
    end
`endif

    always_comb begin
        win_addr = pic_addr;
        win_size = pic_size;
        case (win_id)
            2'd2: begin
                win_addr = wgt_addr;
                win_size = wgt_size;
            end
            2'd3: begin
                win_addr = bias_addr;
                win_size = bias_size;
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_id != 2'd0)  state_nxt = BUSY;
            BUSY:    if (done || wd_fire) state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_req       = busy && !got_beat;
        pic_valid     = mem_valid && busy && (gnt_id == 2'd1);
        wgt_valid     = mem_valid && busy && (gnt_id == 2'd2);
        bias_valid    = mem_valid && busy && (gnt_id == 2'd3);
        pic_last      = pic_valid && mem_last;
        wgt_last      = wgt_valid && mem_last;
        bias_last     = bias_valid && mem_last;
        rd_data       = mem_data;
        rd_last_valid = mem_last_valid;
    end

    // Grant, beat count and watchdog datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_id         <= 2'd0;
            mem_start_addr <= '0;
            mem_size_bytes <= '0;
            beat_cnt       <= 8'd0;
            got_beat       <= 1'b0;
            wd_cnt         <= '0;
            timeout_err    <= 1'b0;
        end else begin
            if (grant) begin
                gnt_id         <= win_id;
                mem_start_addr <= win_addr;
                mem_size_bytes <= win_size;
                beat_cnt       <= 8'd0;
                got_beat       <= 1'b0;
                wd_cnt         <= '0;
            end
            if (busy) begin
                if (mem_valid) begin
                    got_beat <= 1'b1;
                    if (beat_cnt != 8'hFF)
                        beat_cnt <= beat_cnt + 8'd1;
                end else if (!got_beat) begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                end
                if (done || wd_fire)
                    gnt_id <= 2'd0;
                if (wd_fire)
                    timeout_err <= 1'b1;
            end
        end
    end

endmodule
